// File: rtl/vx_ibuffer_arb.sv
// vx_ibuffer_arb
//   Round-robin arbiter that picks one per-warp instruction-buffer requester
//   per cycle and registers its payload into a single issue-port stage.
//
// Parameters
//   NUM_REQS   : number of requesters (1..32)
//   DATA_WIDTH : payload width of one requester
//   SEL_W      : derived, max(1, clog2(NUM_REQS))
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   req_valid  : per-requester valid
//   req_data   : requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_mask   : per-requester eligibility (scoreboard / stall gating)
//   req_ready  : one-hot accept for the granted requester (combinational)
//   out_valid  : issue-port valid (registered)
//   out_data   : issued payload (registered)
//   out_sel    : index of the requester that supplied out_data (registered)
//   out_ready  : downstream accept
//   perf_issued, perf_stalls : saturating event counters, only present when
//                the macro VX_IBUFFER_ARB_PERF_EN is defined
module vx_ibuffer_arb #(
    parameter  int NUM_REQS   = 4,
    parameter  int DATA_WIDTH = 128,
    localparam int SEL_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQS-1:0]            req_mask,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]               out_sel,
    input  logic                           out_ready
`ifdef VX_IBUFFER_ARB_PERF_EN
    ,
    output logic [31:0]                    perf_issued,
    output logic [31:0]                    perf_stalls
`endif
);

    localparam logic [SEL_W:0] NUM_REQS_W = (SEL_W + 1)'(NUM_REQS);

    logic [NUM_REQS-1:0]   eligible;
    logic [2*NUM_REQS-1:0] elig_shift;
    logic [NUM_REQS-1:0]   elig_rot;
    logic                  stage_free;
    logic                  grant_vld;
    logic                  grant;
    logic [SEL_W-1:0]      grant_off;
    logic [SEL_W:0]        grant_sum;
    logic [SEL_W-1:0]      grant_idx;
    logic [SEL_W:0]        ptr_sum;
    logic [SEL_W-1:0]      rr_ptr;
    logic [SEL_W-1:0]      rr_ptr_nxt;
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQS];

    // Stage 0: eligibility, rotated priority search, one-hot ready
    assign eligible   = req_valid & req_mask;
    assign stage_free = !out_valid || out_ready;

    // Rotating the eligible vector by rr_ptr turns the round-robin search
    // into a plain lowest-set-bit search over offsets from rr_ptr.
    assign elig_shift = {eligible, eligible} >> rr_ptr;
    assign elig_rot   = elig_shift[NUM_REQS-1:0];

    always_comb begin
        grant_vld = 1'b0;
        grant_off = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!grant_vld && elig_rot[k]) begin
                grant_vld = 1'b1;
                grant_off = SEL_W'(k);
            end
        end
    end

    // Both operands are below NUM_REQS, so one conditional subtract wraps.
    always_comb begin
        grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
        if (grant_sum >= NUM_REQS_W) begin
            grant_sum = grant_sum - NUM_REQS_W;
        end
        grant_idx = grant_sum[SEL_W-1:0];
    end

    always_comb begin
        ptr_sum = {1'b0, grant_idx} + (SEL_W + 1)'(1);
        if (ptr_sum >= NUM_REQS_W) begin
            ptr_sum = '0;
        end
        rr_ptr_nxt = ptr_sum[SEL_W-1:0];
    end

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            req_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Gating with reset keeps every ready low while reset is held, so no
    // requester believes it handed off a payload that the cleared stage drops.
    assign grant     = grant_vld && stage_free && reset;
    assign req_ready = grant ? (NUM_REQS'(1) << grant_idx) : '0;

    // Stage 1: issue register and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= req_data_arr[grant_idx];
                out_sel   <= grant_idx;
                rr_ptr    <= rr_ptr_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef VX_IBUFFER_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued <= '0;
            perf_stalls <= '0;
        end else begin
            if (out_valid && out_ready) begin
                perf_issued <= sat_inc(perf_issued);
            end
            if (out_valid && !out_ready) begin
                perf_stalls <= sat_inc(perf_stalls);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_ibuffer_arb.sv
module tb_vx_ibuffer_arb;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [511:0] req_data;
    logic [3:0]   req_mask;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;
`ifdef VX_IBUFFER_ARB_PERF_EN
    logic [31:0]  perf_issued;
    logic [31:0]  perf_stalls;
    logic [31:0]  iss0;
    logic [31:0]  stl0;
`endif

    logic         s_req_valid;
    logic [7:0]   s_req_data;
    logic         s_req_mask;
    logic         s_req_ready;
    logic         s_out_valid;
    logic [7:0]   s_out_data;
    logic         s_out_sel;
    logic         s_out_ready;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    vx_ibuffer_arb #(.NUM_REQS(4), .DATA_WIDTH(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef VX_IBUFFER_ARB_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stalls (perf_stalls)
`endif
    );

    vx_ibuffer_arb #(.NUM_REQS(1), .DATA_WIDTH(8)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (s_req_valid),
        .req_data  (s_req_data),
        .req_mask  (s_req_mask),
        .req_ready (s_req_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_sel   (s_out_sel),
        .out_ready (s_out_ready)
`ifdef VX_IBUFFER_ARB_PERF_EN
        ,
        .perf_issued (),
        .perf_stalls ()
`endif
    );

    function automatic logic [127:0] pay(input int i);
        return {4{32'hCAFE_0000 + 32'(i)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic drain();
        req_valid = 4'b0000;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL drain_valid got %0b exp 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b exp 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_sel !== 2'd0) $display("FAIL rst_out_sel got %0d exp 0", out_sel);
        else n_pass++;
        n_total++;
        if (out_data !== 128'd0) $display("FAIL rst_out_data got %h exp 0", out_data);
        else n_pass++;
        n_total++;
        if (req_ready !== 4'b0000) $display("FAIL rst_req_ready got %b exp 0000", req_ready);
        else n_pass++;
`ifdef VX_IBUFFER_ARB_PERF_EN
        n_total++;
        if (perf_issued !== 32'd0 || perf_stalls !== 32'd0)
            $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_issued, perf_stalls);
        else n_pass++;
`endif
        reset = 1'b1;
    endtask

    // All four requesters eligible: sel 0,1,2,3,0 on consecutive edges.
    task automatic test_round_robin();
        req_valid = 4'b1111;
        req_mask  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++;
            if (req_ready !== (4'b0001 << (k % 4)))
                $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, 4'b0001 << (k % 4));
            else n_pass++;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== pay(k % 4))
                $display("FAIL rr_out k=%0d got v=%0b sel=%0d exp v=1 sel=%0d", k, out_valid, out_sel, k % 4);
            else n_pass++;
        end
        drain();
    endtask

    // Sparse valids 1010 from rr_ptr 0: grants 1,3,1,3, never 0 or 2.
    task automatic test_skip();
        int exp_g;
        do_reset();
        req_valid = 4'b1010;
        req_mask  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 1 : 3;
            #1;
            n_total++;
            if (req_ready !== (4'b0001 << exp_g))
                $display("FAIL skip_ready k=%0d got %b exp %b", k, req_ready, 4'b0001 << exp_g);
            else n_pass++;
            tick();
            n_total++;
            if (out_sel !== 2'(exp_g) || out_data !== pay(exp_g))
                $display("FAIL skip_sel k=%0d got %0d exp %0d", k, out_sel, exp_g);
            else n_pass++;
        end
        drain();
    endtask

    // Hold entry from requester 2 for five cycles, then release.
    task automatic test_stall();
        req_valid = 4'b0100;
        req_mask  = 4'b1111;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2)
            $display("FAIL stall_load got v=%0b sel=%0d exp v=1 sel=2", out_valid, out_sel);
        else n_pass++;
`ifdef VX_IBUFFER_ARB_PERF_EN
        iss0 = perf_issued;
        stl0 = perf_stalls;
`endif
        req_valid = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++;
            if (req_ready !== 4'b0000) $display("FAIL stall_ready k=%0d got %b exp 0000", k, req_ready);
            else n_pass++;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== pay(2))
                $display("FAIL stall_hold k=%0d got v=%0b sel=%0d exp v=1 sel=2", k, out_valid, out_sel);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 4'b1000) $display("FAIL stall_resume_ready got %b exp 1000", req_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_sel !== 2'd3 || out_data !== pay(3))
            $display("FAIL stall_resume_sel got %0d exp 3", out_sel);
        else n_pass++;
`ifdef VX_IBUFFER_ARB_PERF_EN
        n_total++;
        if (perf_stalls !== stl0 + 32'd5) $display("FAIL perf_stalls got %0d exp %0d", perf_stalls, stl0 + 32'd5);
        else n_pass++;
        n_total++;
        if (perf_issued !== iss0 + 32'd1) $display("FAIL perf_issued got %0d exp %0d", perf_issued, iss0 + 32'd1);
        else n_pass++;
`endif
        drain();
    endtask

    // Only requester 2 is unmasked; unmasking all continues at 3.
    task automatic test_mask();
        req_valid = 4'b1111;
        req_mask  = 4'b0100;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (req_ready !== 4'b0100) $display("FAIL mask_ready k=%0d got %b exp 0100", k, req_ready);
            else n_pass++;
            tick();
            n_total++;
            if (out_sel !== 2'd2) $display("FAIL mask_sel k=%0d got %0d exp 2", k, out_sel);
            else n_pass++;
        end
        req_mask = 4'b1111;
        #1;
        n_total++;
        if (req_ready !== 4'b1000) $display("FAIL unmask_ready got %b exp 1000", req_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_sel !== 2'd3) $display("FAIL unmask_sel got %0d exp 3", out_sel);
        else n_pass++;
        drain();
    endtask

    // Asynchronous reset mid-operation with rr_ptr at 2.
    task automatic test_async_reset();
        req_valid = 4'b0010;
        req_mask  = 4'b1111;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1)
            $display("FAIL areset_setup got v=%0b sel=%0d exp v=1 sel=1", out_valid, out_sel);
        else n_pass++;
        req_valid = 4'b1111;
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 128'd0)
            $display("FAIL areset_clear got v=%0b sel=%0d exp v=0 sel=0", out_valid, out_sel);
        else n_pass++;
        out_ready = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 4'b0000) $display("FAIL areset_ready got %b exp 0000", req_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL areset_edge got %0b exp 0", out_valid);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 4'b0001) $display("FAIL areset_first_ready got %b exp 0001", req_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== pay(0))
            $display("FAIL areset_first_sel got v=%0b sel=%0d exp v=1 sel=0", out_valid, out_sel);
        else n_pass++;
        drain();
    endtask

    // Single-requester instance: valid 1,0,1 gives out_valid 1,0,1.
    task automatic test_single();
        s_req_valid = 1'b1;
        s_req_data  = 8'h5A;
        #1;
        n_total++;
        if (s_req_ready !== 1'b1) $display("FAIL single_ready got %0b exp 1", s_req_ready);
        else n_pass++;
        tick();
        n_total++;
        if (s_out_valid !== 1'b1 || s_out_sel !== 1'b0 || s_out_data !== 8'h5A)
            $display("FAIL single_out0 got v=%0b d=%h exp v=1 d=5a", s_out_valid, s_out_data);
        else n_pass++;
        s_req_valid = 1'b0;
        #1;
        n_total++;
        if (s_req_ready !== 1'b0) $display("FAIL single_idle_ready got %0b exp 0", s_req_ready);
        else n_pass++;
        tick();
        n_total++;
        if (s_out_valid !== 1'b0) $display("FAIL single_out1 got v=%0b exp 0", s_out_valid);
        else n_pass++;
        s_req_valid = 1'b1;
        s_req_data  = 8'hA5;
        tick();
        n_total++;
        if (s_out_valid !== 1'b1 || s_out_sel !== 1'b0 || s_out_data !== 8'hA5)
            $display("FAIL single_out2 got v=%0b d=%h exp v=1 d=a5", s_out_valid, s_out_data);
        else n_pass++;
        s_req_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        req_valid   = 4'b1111;
        req_mask    = 4'b1111;
        req_data    = {pay(3), pay(2), pay(1), pay(0)};
        out_ready   = 1'b1;
        s_req_valid = 1'b0;
        s_req_data  = 8'h00;
        s_req_mask  = 1'b1;
        s_out_ready = 1'b1;

        test_reset();
        test_round_robin();
        test_skip();
        test_stall();
        test_mask();
        test_async_reset();
        test_single();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
